// File: rtl/acs_array.sv
// Full-trellis add-compare-select for a rate-1/2 Viterbi decoder.
// Tracks per-state validity, normalises and saturates metrics, finds best state.
module acs_array #(
  parameter int K   = 3,
  parameter int G0  = 7,
  parameter int G1  = 5,
  parameter int BMW = 2,
  parameter int PMW = 8,
  localparam int NS = 1 << (K - 1),
  localparam int SW = K - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bm_valid,
  input  logic [4*BMW-1:0] bm,
  output logic             dec_valid,
  output logic [NS-1:0]    decisions,
  output logic [NS-1:0]    state_valid,
  output logic [SW-1:0]    best_state,
  output logic [PMW-1:0]   best_metric,
  output logic             normalized
);

  localparam logic [NS-1:0] VLD0 =
    {{(NS-1){1'b0}}, 1'b1};
  localparam logic [PMW-1:0] HALF =
    {1'b1, {(PMW-1){1'b0}}};

  function automatic int sym_idx(input int p, input int b);
    int r;
    int c0;
    int c1;
    r  = (p << 1) | b;
    c0 = int'(^(r & G0));
    c1 = int'(^(r & G1));
    return c0 * 2 + c1;
  endfunction

  logic [PMW-1:0] pm_q   [NS];
  logic [NS-1:0]  vld_q;

  logic [PMW-1:0] pm_src [NS];
  logic [NS-1:0]  vld_src;
  logic [PMW-1:0] pm_n   [NS];
  logic [NS-1:0]  vld_n;
  logic [NS-1:0]  dec_n;
  logic [PMW-1:0] pm_f   [NS];
  logic           norm_n;
  logic [SW-1:0]  best_n;
  logic [PMW-1:0] bmet_n;

  // A start step runs from the reset pattern, not the held metrics.
  always_comb begin
    vld_src = start ? VLD0 : vld_q;
    for (int s = 0; s < NS; s++)
      pm_src[s] = start ? '0 : pm_q[s];
  end

  for (genvar n = 0; n < NS; n++) begin : g_acs
    localparam int P0 = n >> 1;
    localparam int P1 = P0 | (1 << (K - 2));
    localparam int B  = n & 1;
    localparam int I0 = sym_idx(P0, B);
    localparam int I1 = sym_idx(P1, B);

    logic [PMW:0] c0;
    logic [PMW:0] c1;
    logic [PMW:0] sel;
    logic         d;
    logic         v;

    assign c0 = {1'b0, pm_src[P0]} +
      {{(PMW+1-BMW){1'b0}}, bm[I0*BMW +: BMW]};
    assign c1 = {1'b0, pm_src[P1]} +
      {{(PMW+1-BMW){1'b0}}, bm[I1*BMW +: BMW]};

    always_comb begin
      d   = 1'b0;
      v   = 1'b0;
      sel = '0;
      if (vld_src[P0] && vld_src[P1]) begin
        d   = c0 > c1;
        v   = 1'b1;
        sel = d ? c1 : c0;
      end else if (vld_src[P1]) begin
        d   = 1'b1;
        v   = 1'b1;
        sel = c1;
      end else if (vld_src[P0]) begin
        v   = 1'b1;
        sel = c0;
      end
    end

    assign dec_n[n] = d;
    assign vld_n[n] = v;
    assign pm_n[n]  = sel[PMW] ? '1 : sel[PMW-1:0];
  end

  always_comb begin
    norm_n = |vld_n;
    for (int s = 0; s < NS; s++)
      if (vld_n[s] && !pm_n[s][PMW-1])
        norm_n = 1'b0;
    for (int s = 0; s < NS; s++) begin
      pm_f[s] = '0;
      if (vld_n[s])
        pm_f[s] = norm_n ? pm_n[s] - HALF : pm_n[s];
    end
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    logic found;
    found  = 1'b0;
    best_n = '0;
    bmet_n = '0;
    for (int s = 0; s < NS; s++) begin
      if (vld_n[s] && (!found || pm_f[s] < bmet_n)) begin
        found  = 1'b1;
        best_n = s[SW-1:0];
        bmet_n = pm_f[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NS; s++)
        pm_q[s] <= '0;
      vld_q       <= VLD0;
      dec_valid   <= 1'b0;
      decisions   <= '0;
      best_state  <= '0;
      best_metric <= '0;
      normalized  <= 1'b0;
    end else begin
      dec_valid  <= 1'b0;
      normalized <= 1'b0;
      if (bm_valid) begin
        for (int s = 0; s < NS; s++)
          pm_q[s] <= pm_f[s];
        vld_q       <= vld_n;
        dec_valid   <= 1'b1;
        decisions   <= dec_n;
        best_state  <= best_n;
        best_metric <= bmet_n;
        normalized  <= norm_n;
      end else if (start) begin
        for (int s = 0; s < NS; s++)
          pm_q[s] <= '0;
        vld_q <= VLD0;
      end
    end
  end

  assign state_valid = vld_q;

endmodule
